// File: rtl/sar_search_pkg.sv
// Shared definitions for the SAR operand driver and the magnitude comparator it talks to.
// Relation codes are common to both sides of the compare protocol.
package sar_search_pkg;

  localparam logic [1:0] CMP_EQ  = 2'b11;
  localparam logic [1:0] CMP_GT  = 2'b10;
  localparam logic [1:0] CMP_LT  = 2'b01;
  localparam logic [1:0] CMP_BAD = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sar_search.sv
// Binary-search initiator: drives guesses onto comparator A and narrows [lo,hi]
// from the relation code until A==B, reporting the result and probe count.
module sar_search
  import sar_search_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int CMP_LAT = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [1:0]                  cmp_res,
  output logic [WIDTH-1:0]            guess,
  output logic                        busy,
  output logic                        done,
  output logic [WIDTH-1:0]            found,
  output logic [$clog2(WIDTH+2)-1:0]  probes,
  output logic                        err
);

  localparam int PW = $clog2(WIDTH+2);
  localparam int CW = (CMP_LAT > 0) ? $clog2(CMP_LAT+1) : 1;
  localparam logic [CW-1:0]  WAIT_LOAD = CW'(CMP_LAT);
  localparam logic [WIDTH:0] LO_MIN    = {(WIDTH+1){1'b0}};
  localparam logic [WIDTH:0] HI_MAX    = {1'b0, {WIDTH{1'b1}}};

  state_t           state_r;
  logic [WIDTH:0]   lo_r;
  logic [WIDTH:0]   hi_r;
  logic [CW-1:0]    wait_r;

  logic [WIDTH:0]   guess_ext_s;
  logic [WIDTH:0]   hi_gt_s;
  logic [WIDTH:0]   lo_lt_s;
  logic             cross_gt_s;
  logic             cross_lt_s;

  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH:0] l, input logic [WIDTH:0] h);
    return WIDTH'((l + h) >> 1);
  endfunction

  // Candidate bounds after a GT/LT answer. Since lo<=guess<=hi always holds,
  // the bounds only cross when the responder contradicts an edge of the range.
  always_comb begin
    guess_ext_s = {1'b0, guess};
    hi_gt_s     = guess_ext_s - (WIDTH+1)'(1);
    lo_lt_s     = guess_ext_s + (WIDTH+1)'(1);
    cross_gt_s  = (guess_ext_s <= lo_r);
    cross_lt_s  = (guess_ext_s >= hi_r);
  end

  // Search FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      guess   <= {WIDTH{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      found   <= {WIDTH{1'b0}};
      probes  <= {PW{1'b0}};
      err     <= 1'b0;
      lo_r    <= LO_MIN;
      hi_r    <= HI_MAX;
      wait_r  <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            lo_r    <= LO_MIN;
            hi_r    <= HI_MAX;
            err     <= 1'b0;
            probes  <= {PW{1'b0}};
            found   <= {WIDTH{1'b0}};
            guess   <= midpoint(LO_MIN, HI_MAX);
            wait_r  <= WAIT_LOAD;
            busy    <= 1'b1;
            state_r <= PROBE;
          end else begin
            state_r <= IDLE;
          end
        end
        PROBE: begin
          done <= 1'b0;
          if (wait_r != {CW{1'b0}}) begin
            wait_r <= wait_r - CW'(1);
          end else begin
            probes <= probes + PW'(1);
            case (cmp_res)
              CMP_EQ: begin
                found   <= guess;
                done    <= 1'b1;
                busy    <= 1'b0;
                state_r <= DONE;
              end
              CMP_GT: begin
                if (cross_gt_s) begin
                  err     <= 1'b1;
                  busy    <= 1'b0;
                  state_r <= IDLE;
                end else begin
                  hi_r   <= hi_gt_s;
                  guess  <= midpoint(lo_r, hi_gt_s);
                  wait_r <= WAIT_LOAD;
                end
              end
              CMP_LT: begin
                if (cross_lt_s) begin
                  err     <= 1'b1;
                  busy    <= 1'b0;
                  state_r <= IDLE;
                end else begin
                  lo_r   <= lo_lt_s;
                  guess  <= midpoint(lo_lt_s, hi_r);
                  wait_r <= WAIT_LOAD;
                end
              end
              default: begin
                err     <= 1'b1;
                busy    <= 1'b0;
                state_r <= IDLE;
              end
            endcase
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: a behavioural comparator answers each guess,
// with optional forced faulty codes; one instance per wait latency.
module tb_sar_search;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start2;
  logic [1:0] cmp0, cmp2;
  logic [3:0] guess0, guess2, found0, found2;
  logic       busy0, busy2, done0, done2, err0, err2;
  logic [2:0] probes0, probes2;
  logic [3:0] b0, b2;
  int         mode0;
  int         checks   = 0;
  int         failures = 0;
  logic [31:0] seq;
  int          n;
  logic [3:0]  lat_exp [9] = '{4'd7, 4'd7, 4'd7, 4'd11, 4'd11, 4'd11, 4'd9, 4'd9, 4'd9};

  always #5 clk = ~clk;

  sar_search #(.WIDTH(4), .CMP_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .cmp_res(cmp0), .guess(guess0),
    .busy(busy0), .done(done0), .found(found0), .probes(probes0), .err(err0)
  );

  sar_search #(.WIDTH(4), .CMP_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .cmp_res(cmp2), .guess(guess2),
    .busy(busy2), .done(done2), .found(found2), .probes(probes2), .err(err2)
  );

  function automatic logic [1:0] rel(input logic [3:0] a, input logic [3:0] b);
    if (a == b) return 2'b11;
    else if (a > b) return 2'b10;
    else return 2'b01;
  endfunction

  // Responder for dut0: honest comparator, or a stuck faulty code.
  always_comb begin
    if (mode0 == 1) cmp0 = 2'b10;
    else if (mode0 == 2) cmp0 = 2'b00;
    else cmp0 = rel(guess0, b0);
  end
  assign cmp2 = rel(guess2, b2);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One search on dut0; records the guess seen on each busy cycle (nibble-packed).
  task automatic run0(input logic [3:0] b, input int mode, input int stray_at,
                      output logic [31:0] s, output int cnt);
    b0 = b;
    mode0 = mode;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    s = 32'h0;
    cnt = 0;
    while (busy0 && cnt < 20) begin
      s = {s[27:0], guess0};
      cnt++;
      start0 = (cnt == stray_at) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start0 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start2 = 1'b0; b0 = 4'd0; b2 = 4'd0; mode0 = 0;
    #1;
    check("rst_guess", {28'h0, guess0}, 32'h0);
    check("rst_busy_done_err", {29'h0, busy0, done0, err0}, 32'h0);
    check("rst_found_probes", {25'h0, found0, probes0}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // B=7: hit on first probe
    run0(4'd7, 0, 0, seq, n);
    check("b7_seq", seq, 32'h7);
    check("b7_n", n, 1);
    check("b7_done", {31'h0, done0}, 32'h1);
    check("b7_found", {28'h0, found0}, 32'h7);
    check("b7_probes", {29'h0, probes0}, 32'h1);
    check("b7_err", {31'h0, err0}, 32'h0);
    @(negedge clk);
    check("b7_done_one_cycle", {31'h0, done0}, 32'h0);
    check("b7_found_hold", {28'h0, found0}, 32'h7);

    // B=0: descend to the bottom edge
    run0(4'd0, 0, 0, seq, n);
    check("b0_seq", seq, 32'h7310);
    check("b0_done", {31'h0, done0}, 32'h1);
    check("b0_found", {28'h0, found0}, 32'h0);
    check("b0_probes", {29'h0, probes0}, 32'h4);

    // B=15 worst case, with a stray start mid-search that must be ignored
    run0(4'd15, 0, 2, seq, n);
    check("b15_seq", seq, 32'h7BDEF);
    check("b15_done", {31'h0, done0}, 32'h1);
    check("b15_found", {28'h0, found0}, 32'hF);
    check("b15_probes", {29'h0, probes0}, 32'h5);
    @(negedge clk);

    // Responder always says A>B: bounds cross after guess 0
    run0(4'd9, 1, 0, seq, n);
    check("gt_seq", seq, 32'h7310);
    check("gt_err", {31'h0, err0}, 32'h1);
    check("gt_done", {31'h0, done0}, 32'h0);
    check("gt_probes", {29'h0, probes0}, 32'h4);
    mode0 = 0;

    // Invalid code on the 2nd probe
    b0 = 4'd3;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    @(negedge clk);
    check("bad_guess2", {28'h0, guess0}, 32'h3);
    mode0 = 2;
    @(negedge clk);
    check("bad_err_busy_done", {29'h0, err0, busy0, done0}, 32'h4);
    check("bad_probes", {29'h0, probes0}, 32'h2);
    @(negedge clk);
    check("bad_no_done_later", {30'h0, err0, done0}, 32'h2);
    mode0 = 0;

    // Next start clears the sticky error
    run0(4'd5, 0, 0, seq, n);
    check("b5_seq", seq, 32'h735);
    check("b5_err_done", {30'h0, err0, done0}, 32'h1);
    check("b5_found", {28'h0, found0}, 32'h5);
    @(negedge clk);

    // Reset during the 3rd probe of B=12
    b0 = 4'd12;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b12_third_guess", {28'h0, guess0}, 32'hD);
    rst = 1'b1;
    #1;
    check("mid_rst_guess", {28'h0, guess0}, 32'h0);
    check("mid_rst_flags", {29'h0, busy0, done0, err0}, 32'h0);
    check("mid_rst_found_probes", {25'h0, found0, probes0}, 32'h0);
    @(negedge clk) rst = 1'b0;
    run0(4'd12, 0, 0, seq, n);
    check("b12_seq", seq, 32'h7BDC);
    check("b12_found", {28'h0, found0}, 32'hC);
    check("b12_err_done", {30'h0, err0, done0}, 32'h1);

    // CMP_LAT=2, B=9: each guess held 3 cycles, done 10 edges after start
    b2 = 4'd9;
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    n = 0;
    while (busy2 && n < 30) begin
      if (n < 9) check("lat2_guess", {28'h0, guess2}, {28'h0, lat_exp[n]});
      n++;
      @(negedge clk);
    end
    check("lat2_start_to_done", n + 1, 10);
    check("lat2_done", {31'h0, done2}, 32'h1);
    check("lat2_found", {28'h0, found2}, 32'h9);
    check("lat2_probes", {29'h0, probes2}, 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
